// File: rtl/frame_feeder_if.sv
// Handshake bundle between the frame feeder, its host/DMA loader and the
// Conv2D line-buffer controller. The master side drives requests; the slave
// side (the feeder) drives data and status.
interface frame_feeder_if #(
    parameter int AW = 14
);
    logic          load_start;
    logic          ld_valid;
    logic [31:0]   ld_data;
    logic          ld_ready;
    logic          start;
    logic          data_in_en;
    logic [31:0]   data;
    logic          data_valid;
    logic [AW-1:0] row_idx;
    logic          row_end;
    logic          loaded;
    logic          done;
    logic          underrun;

    modport master (
        output load_start, ld_valid, ld_data, start, data_in_en,
        input  ld_ready, data, data_valid, row_idx, row_end, loaded, done, underrun
    );

    modport slave (
        input  load_start, ld_valid, ld_data, start, data_in_en,
        output ld_ready, data, data_valid, row_idx, row_end, loaded, done, underrun
    );
endinterface

// File: rtl/frame_feeder.sv
// Frame feeder: holds one input feature map in on-chip RAM, loaded word by
// word from the host, then returns one word per Conv2D request with a
// one-cycle latency, tagging each word with its row and an end-of-row flag.
module frame_feeder #(
    parameter int ROW_WORDS = 96,
    parameter int ROWS      = 102
) (
    input  logic           clk,
    input  logic           rst,
    frame_feeder_if.slave  bus
);
    localparam int DEPTH = ROWS * ROW_WORDS;
    localparam int AW    = $clog2(DEPTH + 1);
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(ROW_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_col;
    logic [AW-1:0] r_row;
    logic [31:0]   r_data;
    logic          r_data_valid;
    logic [AW-1:0] r_row_idx;
    logic          r_row_end;
    logic          r_ld_ready;
    logic          r_loaded;
    logic          r_done;
    logic          r_underrun;

    logic [31:0]   r_mem [DEPTH];
    logic          w_wr_en;

    assign w_wr_en = (r_state == S_LOAD) && bus.ld_valid;

    // Frame storage: one write port fed by the host during LOAD.
    // NOTE: the RAM array has no reset so it maps onto block RAM; only the
    // pointers and flags that say what it holds are reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[IW-1:0]] <= bus.ld_data;
        end
    end

    // Control FSM with registered outputs: load, stream with row tracking, status.
    // NOTE: every state register uses <= so all of them update from the same
    // pre-edge values, exactly as the flops in hardware do.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_row_idx    <= '0;
            r_row_end    <= 1'b0;
            r_ld_ready   <= 1'b0;
            r_loaded     <= 1'b0;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            // data_valid and row_end are single-cycle qualifiers of data
            r_data_valid <= 1'b0;
            r_row_end    <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.load_start) begin
                        r_state    <= S_LOAD;
                        r_wr_ptr   <= '0;
                        r_loaded   <= 1'b0;
                        r_done     <= 1'b0;
                        r_underrun <= 1'b0;
                        r_ld_ready <= 1'b1;
                    end else if (bus.start && r_loaded) begin
                        r_state  <= S_STREAM;
                        r_rd_ptr <= '0;
                        r_col    <= '0;
                        r_row    <= '0;
                        r_done   <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (bus.ld_valid) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (r_wr_ptr == LAST_PTR) begin
                            r_state    <= S_IDLE;
                            r_loaded   <= 1'b1;
                            r_ld_ready <= 1'b0;
                        end
                    end
                end

                S_STREAM: begin
                    if (bus.data_in_en) begin
                        r_data       <= r_mem[r_rd_ptr[IW-1:0]];
                        r_data_valid <= 1'b1;
                        r_row_idx    <= r_row;
                        r_row_end    <= (r_col == LAST_COL);
                        r_rd_ptr     <= r_rd_ptr + 1'b1;
                        if (r_col == LAST_COL) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                        if (r_rd_ptr == LAST_PTR) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase

            // A request outside STREAM is never served; flag it until cleared
            if (bus.data_in_en && (r_state != S_STREAM)) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign bus.ld_ready   = r_ld_ready;
    assign bus.data       = r_data;
    assign bus.data_valid = r_data_valid;
    assign bus.row_idx    = r_row_idx;
    assign bus.row_end    = r_row_end;
    assign bus.loaded     = r_loaded;
    assign bus.done       = r_done;
    assign bus.underrun   = r_underrun;
endmodule
